// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;
    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

    localparam int RF_WIDTH_DEF = 8;
    localparam int RF_NREGS_DEF = 4;
endpackage

// File: rtl/regfile_mp_read_port.sv
// One registered read port: read mux, write-first bypass, rdata/rvalid registers.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        re,
    input  logic [AW-1:0]               raddr,
    input  logic [NREGS-1:0][WIDTH-1:0] regs,
    input  logic                        wen,
    input  logic [AW-1:0]               waddr,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        rvalid
);
    logic hit;

    assign hit = wen && (waddr == raddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re)
                rdata <= hit ? wdata : regs[raddr];
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two registered read ports, one write port,
// dirty mask and a one-register-per-cycle clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b,
    input  logic             clr,
    output logic             busy,
    output logic [NREGS-1:0] dirty
);
    logic [NREGS-1:0][WIDTH-1:0] regs;
    rf_state_t                   state;
    logic [AW-1:0]               ptr;

    logic                        sweep;
    logic                        user_we;
    logic                        wen;
    logic [AW-1:0]               wa;
    logic [WIDTH-1:0]            wd;

    // The sweep owns the write port; user writes lose to it and to a new clr.
    assign sweep   = (state == RF_CLEAR);
    assign user_we = we && !sweep && !clr;
    assign wen     = user_we || sweep;
    assign wa      = sweep ? ptr : waddr;
    assign wd      = sweep ? '0 : wdata;
    assign busy    = sweep;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs  <= '0;
            dirty <= '0;
            state <= RF_IDLE;
            ptr   <= '0;
        end else begin
            if (wen)
                regs[wa] <= wd;
            if (user_we)
                dirty[waddr] <= 1'b1;
            if (sweep)
                dirty[ptr] <= 1'b0;
            case (state)
                RF_IDLE: begin
                    if (clr) begin
                        state <= RF_CLEAR;
                        ptr   <= '0;
                    end
                end
                RF_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == AW'(NREGS - 1))
                        state <= RF_IDLE;
                end
                default: state <= RF_IDLE;
            endcase
        end
    end

    logic [1:0]           re_v;
    logic [1:0][AW-1:0]   raddr_v;
    logic [1:0][WIDTH-1:0] rdata_v;
    logic [1:0]           rvalid_v;

    assign re_v    = {re_b, re_a};
    assign raddr_v = {raddr_b, raddr_a};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        rf_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rd (
            .clk    (clk),
            .rst    (rst),
            .re     (re_v[p]),
            .raddr  (raddr_v[p]),
            .regs   (regs),
            .wen    (wen),
            .waddr  (wa),
            .wdata  (wd),
            .rdata  (rdata_v[p]),
            .rvalid (rvalid_v[p])
        );
    end

    assign rdata_a  = rdata_v[0];
    assign rvalid_a = rvalid_v[0];
    assign rdata_b  = rdata_v[1];
    assign rvalid_b = rvalid_v[1];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp: default 8x4 instance plus a 16x8 instance.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit x 4 instance
    logic       we, re_a, re_b, clr, busy, rvalid_a, rvalid_b;
    logic [1:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata, rdata_a, rdata_b;
    logic [3:0] dirty;

    // 16-bit x 8 instance
    logic        we1, re_a1, re_b1, clr1, busy1, rvalid_a1, rvalid_b1;
    logic [2:0]  waddr1, raddr_a1, raddr_b1;
    logic [15:0] wdata1, rdata_a1, rdata_b1;
    logic [7:0]  dirty1;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
        .clr(clr), .busy(busy), .dirty(dirty)
    );

    regfile_mp #(.WIDTH(16), .NREGS(8)) u_dut16 (
        .clk(clk), .rst(rst), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .re_a(re_a1), .raddr_a(raddr_a1), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
        .re_b(re_b1), .raddr_b(raddr_b1), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
        .clr(clr1), .busy(busy1), .dirty(dirty1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cnt;

    initial begin
        rst = 1'b1;
        we = 0; waddr = 0; wdata = 0; re_a = 0; raddr_a = 0; re_b = 0; raddr_b = 0; clr = 0;
        we1 = 0; waddr1 = 0; wdata1 = 0; re_a1 = 0; raddr_a1 = 0; re_b1 = 0; raddr_b1 = 0; clr1 = 0;
        tick(); tick();
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rdata_a",  32'(rdata_a),  32'h00);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_dirty",    32'(dirty),    32'h0);
        rst = 1'b0;

        // idle read
        re_a = 1; raddr_a = 3;
        tick();
        re_a = 0;
        chk("idle_rvalid_a", 32'(rvalid_a), 32'd1);
        chk("idle_rdata_a",  32'(rdata_a),  32'h00);
        chk("idle_dirty",    32'(dirty),    32'h0);

        // write then read on port B
        we = 1; waddr = 2; wdata = 8'hA5;
        tick();
        we = 0;
        chk("wr_dirty", 32'(dirty), 32'b0100);
        re_b = 1; raddr_b = 2;
        tick();
        re_b = 0;
        chk("wr_rdata_b",  32'(rdata_b),  32'hA5);
        chk("wr_rvalid_b", 32'(rvalid_b), 32'd1);
        tick();
        chk("hold_rvalid_b", 32'(rvalid_b), 32'd0);
        chk("hold_rdata_b",  32'(rdata_b),  32'hA5);

        // same-cycle bypass on both ports
        we = 1; waddr = 1; wdata = 8'h3C; re_a = 1; raddr_a = 1; re_b = 1; raddr_b = 1;
        tick();
        we = 0; re_a = 0; re_b = 0;
        chk("byp_rdata_a",  32'(rdata_a),  32'h3C);
        chk("byp_rdata_b",  32'(rdata_b),  32'h3C);
        chk("byp_rvalid_a", 32'(rvalid_a), 32'd1);
        chk("byp_rvalid_b", 32'(rvalid_b), 32'd1);
        chk("byp_dirty",    32'(dirty),    32'b0110);

        // fill and sweep
        for (int i = 0; i < 4; i++) begin
            we = 1; waddr = 2'(i); wdata = 8'(8'h11 * (i + 1));
            tick();
        end
        we = 0;
        chk("fill_dirty", 32'(dirty), 32'hF);
        re_a = 1; raddr_a = 3;
        tick();
        re_a = 0;
        chk("fill_rd3", 32'(rdata_a), 32'h44);
        clr = 1;
        tick();
        clr = 0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            // reg0 is already swept here: a leaked write would survive the sweep
            if (cnt == 2) begin we = 1; waddr = 0; wdata = 8'h99; clr = 1; end
            else begin we = 0; clr = 0; end
            tick();
        end
        we = 0; clr = 0;
        chk("sweep_busy_cycles", 32'(cnt), 32'd4);
        chk("sweep_dirty",       32'(dirty), 32'h0);
        for (int i = 0; i < 4; i++) begin
            re_a = 1; raddr_a = 2'(i);
            tick();
            chk($sformatf("sweep_rd%0d", i), 32'(rdata_a), 32'h00);
        end
        re_a = 0;

        // first write after the sweep is accepted
        we = 1; waddr = 2; wdata = 8'h5A;
        tick();
        we = 1; waddr = 3; wdata = 8'h77;
        tick();
        we = 0;
        chk("post_dirty", 32'(dirty), 32'b1100);
        re_b = 1; raddr_b = 2;
        tick();
        re_b = 0;
        chk("post_rd2", 32'(rdata_b), 32'h5A);

        // clr and we collide: write dropped, sweep starts
        clr = 1; we = 1; waddr = 0; wdata = 8'hFF;
        tick();
        clr = 0; we = 0;
        chk("coll_busy",  32'(busy),  32'd1);
        chk("coll_dirty", 32'(dirty), 32'b1100);
        tick();
        // reset in sweep cycle 2, with a read request pending
        rst = 1; re_a = 1; raddr_a = 3;
        tick();
        rst = 0; re_a = 0;
        chk("mrst_busy",     32'(busy),     32'd0);
        chk("mrst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("mrst_rdata_a",  32'(rdata_a),  32'h00);
        chk("mrst_dirty",    32'(dirty),    32'h0);
        for (int i = 0; i < 4; i++) begin
            re_a = 1; raddr_a = 2'(i);
            tick();
            chk($sformatf("mrst_rd%0d", i), 32'(rdata_a), 32'h00);
        end
        re_a = 0;

        // 16x8 instance
        we1 = 1; waddr1 = 7; wdata1 = 16'hBEEF;
        tick();
        we1 = 0;
        chk("w16_dirty", 32'(dirty1), 32'h80);
        re_a1 = 1; raddr_a1 = 7; re_b1 = 1; raddr_b1 = 7;
        tick();
        re_a1 = 0; re_b1 = 0;
        chk("w16_rdata_a", 32'(rdata_a1), 32'hBEEF);
        chk("w16_rdata_b", 32'(rdata_b1), 32'hBEEF);
        clr1 = 1;
        tick();
        clr1 = 0;
        cnt = 0;
        while (busy1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("w16_busy_cycles", 32'(cnt), 32'd8);
        chk("w16_sweep_dirty", 32'(dirty1), 32'h0);
        re_a1 = 1; raddr_a1 = 7;
        tick();
        re_a1 = 0;
        chk("w16_sweep_rd7", 32'(rdata_a1), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised register file with two registered read ports and one write port, for the datapath where the original 4×8 register file sits. Adds configurable width/depth, same-cycle write-to-read bypass, a per-register dirty mask and a sequenced clear operation that zeroes one register per cycle. Read ports carry a valid strobe so downstream stages can use a one-cycle read pipeline.

## Interface
- WIDTH, 8: data width in bits.
- NREGS, 4: number of registers; power of two, at least 2.
- AW, $clog2(NREGS): address width; derived, do not override.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write request.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- re_a  in  1  read request, port A.
- raddr_a  in  AW  read address, port A.
- rdata_a  out  WIDTH  registered read data, port A.
- rvalid_a  out  1  rdata_a valid strobe.
- re_b, raddr_b, rdata_b, rvalid_b: same as port A, for port B.
- clr  in  1  start a clear sweep.
- busy  out  1  clear sweep in progress.
- dirty  out  NREGS  bit i set if register i has been user-written since the last reset or clear.

## Operation
- Reset (rst=1 at an edge): all registers 0, dirty 0, rdata_a/b 0, rvalid_a/b 0, busy 0, state RF_IDLE, sweep pointer 0. Reset overrides every other input, including in the middle of a sweep.
- Write: when we=1 and the block is idle (not busy, no clr this cycle), reg[waddr] <= wdata and dirty[waddr] <= 1.
- Writes are dropped with no error when busy=1, or when clr=1 in the same cycle.
- Read: re_x=1 at edge N loads rdata_x and sets rvalid_x=1 for the cycle after N.
  - re_x=0: rvalid_x=0 and rdata_x holds its last value.
- Bypass (write-first): if a write is effective at the same edge and targets raddr_x, rdata_x gets the written value (wdata, or 0 for a sweep write), not the old contents.
- Both ports may read the same address. Both ports may read the write address at the same time; both are bypassed.
- FSM states:
  - RF_IDLE: clr=1 moves to RF_CLEAR with ptr=0.
  - RF_CLEAR: each cycle writes reg[ptr] <= 0, dirty[ptr] <= 0, ptr <= ptr+1. At ptr==NREGS-1 the last register is cleared and the FSM returns to RF_IDLE.
- clr while busy is ignored; it does not restart the sweep.
- Reads stay legal during a sweep and return each register's current contents. A register at or below the sweep pointer reads 0.
- Addresses always lie in range; the pointer wraps naturally from NREGS-1 and there is no out-of-range case.

## Timing
- Read latency is 1 cycle, request to rvalid/rdata. Full throughput: one read per port per cycle.
- Write takes effect at the sampling edge and is visible to a read requested in the same cycle through the bypass.
- busy rises the cycle after clr is sampled and stays high for exactly NREGS cycles. The first write accepted after a sweep is in the cycle busy is low again.
- dirty updates at the same edge as the write or sweep that changes it.

## Structure
- Package regfile_pkg:
  - rf_state_t enum {RF_IDLE, RF_CLEAR}.
  - Default WIDTH/NREGS localparams.
- Sub-module rf_read_port, instantiated twice. It holds the read mux, the bypass compare and the rdata/rvalid registers.
- Top level holds the storage array, write enable gating, the sweep FSM/pointer and the dirty mask.

## Test plan
- Reset then idle reads: assert rst 2 cycles; re_a=1 raddr_a=3 -> next cycle rvalid_a=1 rdata_a=0x00, dirty=0000, busy=0.
- Write/read, defaults: we waddr=2 wdata=0xA5; next cycle re_b raddr_b=2 -> rdata_b=0xA5 one cycle later, dirty=0100.
- Bypass: same cycle we waddr=1 wdata=0x3C, re_a raddr_a=1, re_b raddr_b=1 -> next cycle rdata_a=rdata_b=0x3C, both rvalid=1.
- Sweep: fill regs with 0x11..0x44, pulse clr -> busy high exactly 4 cycles. Writes issued while busy are dropped. Then all registers read 0, dirty=0000. A second clr pulsed mid-sweep does not extend busy.
- clr/we collision and reset mid-sweep: clr and we(waddr=0, 0xFF) in the same cycle -> reg0 reads 0. rst at sweep cycle 2 -> next cycle busy=0, all regs 0, rvalid 0.
- WIDTH=16, NREGS=8: write 0xBEEF to reg 7, read on both ports -> 0xBEEF. Sweep -> busy 8 cycles.
